result_collector: RTL and testbench

RESULT_COLLECTOR -- requirements
Module: result_collector

---
 rtl/result_collector_pkg.sv | 24 ++
 rtl/result_collector_decoder.sv | 21 ++
 rtl/result_collector.sv | 141 ++++++++++++++
 tb/tb_result_collector.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/result_collector_pkg.sv
// Shared definitions for the result collector: FSM encoding and the field
// layout of the one-byte page result reported over the UART.
package result_collector_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_POP     = 3'd2,
    S_CAPTURE = 3'd3,
    S_DECODE  = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam int FMT_BIT  = 7;
  localparam int PASS_BIT = 6;
  localparam int RSVD_MSB = 5;
  localparam int RSVD_LSB = 4;
  localparam int PAGE_MSB = 3;
  localparam int PAGE_LSB = 0;

  localparam int DEFAULT_NUM_PAGES = 14;
  localparam int COUNT_W           = 5;

endpackage

// File: rtl/result_collector_decoder.sv
// Splits a result byte into page/pass fields and flags whether it is well
// formed for a run of NUM_PAGES pages.
module result_byte_decoder
  import result_collector_pkg::*;
#(
  parameter int NUM_PAGES = DEFAULT_NUM_PAGES
) (
  input  logic [7:0] result_byte,
  output logic [3:0] page,
  output logic       pass,
  output logic       format_ok
);

  assign page = result_byte[PAGE_MSB:PAGE_LSB];
  assign pass = result_byte[PASS_BIT];

  assign format_ok = !result_byte[FMT_BIT]
                  && (result_byte[RSVD_MSB:RSVD_LSB] == 2'b00)
                  && ({1'b0, page} < 5'(NUM_PAGES));

endmodule

// File: rtl/result_collector.sv
// Pops page-result bytes from the UART RX FIFO, records pass/fail per page
// and flags sequencing, format and inactivity errors for one test run.
module result_collector
  import result_collector_pkg::*;
#(
  parameter int NUM_PAGES      = DEFAULT_NUM_PAGES,
  parameter int TIMEOUT_CYCLES = 25000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 rx_empty,
  input  logic [7:0]           rx_data,
  output logic                 rx_read,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_PAGES-1:0] pass_mask,
  output logic [NUM_PAGES-1:0] recv_mask,
  output logic [COUNT_W-1:0]   pass_count,
  output logic [COUNT_W-1:0]   fail_count,
  output logic                 all_pass,
  output logic                 seq_error,
  output logic                 format_error,
  output logic                 timeout
);

  localparam int                   TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0]      TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [COUNT_W-1:0]   PAGES_C = COUNT_W'(NUM_PAGES);

  state_t               state, state_next;
  logic [7:0]           byte_reg;
  logic [TO_W-1:0]      to_cnt;
  logic [4:0]           expected_page;

  logic [3:0]           dec_page;
  logic                 dec_pass;
  logic                 dec_ok;
  logic [NUM_PAGES-1:0] page_bit;
  logic                 dup;
  logic                 accept;
  logic                 to_hit;
  logic [COUNT_W-1:0]   recv_after;

  result_byte_decoder #(
    .NUM_PAGES(NUM_PAGES)
  ) u_decoder (
    .result_byte(byte_reg),
    .page       (dec_page),
    .pass       (dec_pass),
    .format_ok  (dec_ok)
  );

  assign page_bit   = NUM_PAGES'(1) << dec_page;
  assign dup        = |(recv_mask & page_bit);
  assign accept     = (state == S_DECODE) && dec_ok && !dup;
  assign recv_after = pass_count + fail_count + COUNT_W'(1);
  assign to_hit     = (state == S_WAIT) && rx_empty && (to_cnt == TO_LAST);

  always_comb begin
    state_next = state;
    if (start) begin
      state_next = S_WAIT;
    end else begin
      case (state)
        S_IDLE:    state_next = S_IDLE;
        S_WAIT: begin
          if (!rx_empty)   state_next = S_POP;
          else if (to_hit) state_next = S_DONE;
        end
        S_POP:     state_next = S_CAPTURE;
        S_CAPTURE: state_next = S_DECODE;
        S_DECODE:  state_next = (accept && recv_after == PAGES_C) ? S_DONE : S_WAIT;
        S_DONE:    state_next = S_DONE;
        default:   state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      byte_reg      <= '0;
      to_cnt        <= '0;
      expected_page <= '0;
      pass_mask     <= '0;
      recv_mask     <= '0;
      pass_count    <= '0;
      fail_count    <= '0;
      seq_error     <= 1'b0;
      format_error  <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      state <= state_next;
      if (start) begin
        to_cnt        <= '0;
        expected_page <= '0;
        pass_mask     <= '0;
        recv_mask     <= '0;
        pass_count    <= '0;
        fail_count    <= '0;
        seq_error     <= 1'b0;
        format_error  <= 1'b0;
        timeout       <= 1'b0;
      end else begin
        case (state)
          S_WAIT: begin
            if (rx_empty) begin
              if (to_hit) timeout <= 1'b1;
              else        to_cnt  <= to_cnt + TO_W'(1);
            end
          end
          S_CAPTURE: byte_reg <= rx_data;
          S_DECODE: begin
            to_cnt <= '0;
            if (!dec_ok) begin
              format_error <= 1'b1;
            end else if (dup) begin
              seq_error <= 1'b1;
            end else begin
              // Out-of-order pages are flagged but still recorded.
              if ({1'b0, dec_page} != expected_page) seq_error <= 1'b1;
              recv_mask     <= recv_mask | page_bit;
              pass_mask     <= dec_pass ? (pass_mask | page_bit) : (pass_mask & ~page_bit);
              expected_page <= {1'b0, dec_page} + 5'd1;
              if (dec_pass) pass_count <= pass_count + COUNT_W'(1);
              else          fail_count <= fail_count + COUNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign rx_read  = (state == S_POP);
  assign busy     = (state != S_IDLE) && (state != S_DONE);
  assign done     = (state == S_DONE);
  assign all_pass = done && !timeout && (fail_count == '0) && !seq_error && !format_error;

endmodule

// File: tb/tb_result_collector.sv
// Randomized and directed bench for result_collector against a byte-level
// model of the collection rules, with a behavioural RX FIFO.
module tb_result_collector;

  localparam int NP = 14;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          rx_empty = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_read;
  logic          busy;
  logic          done;
  logic [NP-1:0] pass_mask;
  logic [NP-1:0] recv_mask;
  logic [4:0]    pass_count;
  logic [4:0]    fail_count;
  logic          all_pass;
  logic          seq_error;
  logic          format_error;
  logic          timeout;

  result_collector #(
    .NUM_PAGES     (NP),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .rx_empty    (rx_empty),
    .rx_data     (rx_data),
    .rx_read     (rx_read),
    .busy        (busy),
    .done        (done),
    .pass_mask   (pass_mask),
    .recv_mask   (recv_mask),
    .pass_count  (pass_count),
    .fail_count  (fail_count),
    .all_pass    (all_pass),
    .seq_error   (seq_error),
    .format_error(format_error),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic [7:0] q[$];

  // Behavioural RX FIFO: pops mid-cycle, so data is stable before CAPTURE.
  always @(negedge clk) begin
    if (rx_read && q.size() > 0) rx_data = q.pop_front();
    rx_empty = (q.size() == 0);
  end

  // Reference model of one run, updated per consumed byte.
  bit m_recv[16];
  bit m_pass[16];
  int m_pc, m_fc, m_exp;
  bit m_seq, m_fmt, m_to, m_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic model_clear();
    for (int p = 0; p < 16; p++) begin
      m_recv[p] = 1'b0;
      m_pass[p] = 1'b0;
    end
    m_pc = 0; m_fc = 0; m_exp = 0;
    m_seq = 0; m_fmt = 0; m_to = 0; m_done = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int bi, pg;
    bi = int'(b);
    pg = bi % 16;
    if (bi >= 128 || ((bi / 16) % 4) != 0 || pg >= NP) begin
      m_fmt = 1;
    end else if (m_recv[pg]) begin
      m_seq = 1;
    end else begin
      if (pg != m_exp) m_seq = 1;
      m_recv[pg] = 1;
      m_pass[pg] = ((bi / 64) % 2) == 1;
      if (m_pass[pg]) m_pc++;
      else            m_fc++;
      m_exp = pg + 1;
      if (m_pc + m_fc == NP) m_done = 1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    model_byte(b);
    q.push_back(b);
  endtask

  task automatic do_start();
    q.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    model_clear();
  endtask

  task automatic drain(input string t);
    int n = 0;
    while (q.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    check({t, ".drained"}, 32'(q.size()), 32'd0);
    repeat (5) tick();
  endtask

  task automatic compare_all(input string t);
    logic [NP-1:0] rm, pm;
    rm = '0;
    pm = '0;
    for (int p = 0; p < NP; p++) begin
      rm[p] = m_recv[p];
      pm[p] = m_pass[p];
    end
    check({t, ".recv_mask"}, 32'(recv_mask), 32'(rm));
    check({t, ".pass_mask"}, 32'(pass_mask), 32'(pm));
    check({t, ".pass_count"}, 32'(pass_count), 32'(m_pc));
    check({t, ".fail_count"}, 32'(fail_count), 32'(m_fc));
    check({t, ".seq_error"}, 32'(seq_error), 32'(m_seq));
    check({t, ".format_error"}, 32'(format_error), 32'(m_fmt));
    check({t, ".timeout"}, 32'(timeout), 32'(m_to));
    check({t, ".done"}, 32'(done), 32'(m_done));
    check({t, ".busy"}, 32'(busy), 32'(!m_done));
    check({t, ".all_pass"}, 32'(all_pass),
          32'(m_done && !m_to && m_fc == 0 && !m_seq && !m_fmt));
  endtask

  task automatic check_zero(input string t);
    check({t, ".rx_read"}, 32'(rx_read), 32'd0);
    check({t, ".busy"}, 32'(busy), 32'd0);
    check({t, ".done"}, 32'(done), 32'd0);
    check({t, ".masks"}, 32'({pass_mask, recv_mask}), 32'd0);
    check({t, ".counts"}, 32'({pass_count, fail_count}), 32'd0);
    check({t, ".flags"}, 32'({seq_error, format_error, timeout, all_pass}), 32'd0);
  endtask

  task automatic send_random();
    int k, pg;
    logic pb;
    logic [7:0] b;
    k  = $urandom_range(0, 19);
    pb = ($urandom_range(0, 5) != 0);
    pg = (m_exp < NP) ? m_exp : $urandom_range(0, NP - 1);
    if (k < 12)      b = {1'b0, pb, 2'b00, 4'(pg)};
    else if (k < 15) b = {1'b0, pb, 2'b00, 4'($urandom_range(0, NP - 1))};
    else if (k < 17) b = 8'($urandom_range(0, 255));
    else             b = {1'b0, pb, 2'b00, 4'($urandom_range(NP, 15))};
    send(b);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int rd_cyc[$];
    int n, hits;

    model_clear();
    repeat (3) tick();
    reset = 1'b0;
    check_zero("reset");

    // All pages pass, in order.
    do_start();
    for (int i = 0; i < NP; i++) send(8'h40 + 8'(i));
    drain("allpass");
    compare_all("allpass");
    check("allpass.mask_const", 32'(pass_mask), 32'h3FFF);
    check("allpass.flag_const", 32'(all_pass), 32'd1);

    // Page 3 fails.
    do_start();
    for (int i = 0; i < NP; i++) send((i == 3) ? 8'h03 : 8'h40 + 8'(i));
    drain("onefail");
    compare_all("onefail");
    check("onefail.mask_const", 32'(pass_mask), 32'h3FF7);

    // Skip then duplicate.
    do_start();
    send(8'h40);
    send(8'h42);
    drain("skip");
    check("skip.seq", 32'(seq_error), 32'd1);
    check("skip.recv", 32'(recv_mask), 32'h5);
    send(8'h42);
    drain("dup");
    check("dup.pass_count", 32'(pass_count), 32'd2);
    compare_all("dup");

    // Malformed bytes.
    do_start();
    send(8'h8F);
    send(8'h30);
    send(8'h4E);
    drain("fmt");
    compare_all("fmt");
    check("fmt.busy_const", 32'(busy), 32'd1);

    for (int r = 0; r < 10; r++) begin
      do_start();
      for (int i = 0; i < 30 && !m_done; i++) send_random();
      drain($sformatf("rand%0d", r));
      compare_all($sformatf("rand%0d", r));
    end

    // Inactivity timeout after five pages.
    do_start();
    for (int i = 0; i < 5; i++) send(8'h40 + 8'(i));
    drain("to_pre");
    compare_all("to_pre");
    repeat (40) tick();
    check("to.not_early", 32'(done), 32'd0);
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    m_to = 1;
    m_done = 1;
    compare_all("to");
    q.push_back(8'h45);
    hits = 0;
    repeat (30) begin
      tick();
      if (rx_read) hits++;
    end
    check("to.no_reads", 32'(hits), 32'd0);

    // Restart mid-run, then back-to-back throughput, then reset during POP.
    do_start();
    for (int i = 0; i < 7; i++) send(8'h40 + 8'(i));
    drain("mid");
    check("mid.pass_count", 32'(pass_count), 32'd7);
    do_start();
    compare_all("restart");
    for (int i = 0; i < 6; i++) send(8'h40 + 8'(i));
    repeat (40) begin
      tick();
      if (rx_read) rd_cyc.push_back(cyc);
    end
    check("b2b.pops", 32'(rd_cyc.size()), 32'd6);
    for (int i = 1; i < rd_cyc.size(); i++)
      check($sformatf("b2b.gap%0d", i), 32'(rd_cyc[i] - rd_cyc[i-1]), 32'd4);
    compare_all("b2b");
    send(8'h46);
    send(8'h47);
    n = 0;
    while (!rx_read && n < 50) begin
      tick();
      n++;
    end
    check("rstpop.seen_pop", 32'(rx_read), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_zero("rstpop");
    tick();
    check("rstpop.idle_read", 32'(rx_read), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
